dma_copy: RTL and testbench
===========================

DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 Parameter: LEN_WIDTH, default 16, word-count register width (1..16).
REQ-002 clk  in  1  sole clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 select  in  1  config-port slave select, decoded by the top-level address map.
REQ-005 wstrb  in  4  config-port byte write strobes; 0 = read.
REQ-006 addr  in  4  config-port byte offset; only [3:2] decoded.
REQ-007 data_i  in  32  config-port write data.
REQ-008 ready  out  1  config-port access complete.
REQ-009 data_o  out  32  config-port read data, valid while ready=1.
REQ-010 m_grant  in  1  bus granted to this master by the external arbiter.
REQ-011 m_valid  out  1  master request valid.
REQ-012 m_addr  out  32  master word-aligned byte address.
REQ-013 m_wstrb  out  4  master write strobes; 0000 = read.
REQ-014 m_wdata  out  32  master write data.
REQ-015 m_ready  in  1  responder completed the master request.
REQ-016 m_rdata  in  32  read data, sampled when m_valid=1 and m_ready=1.
REQ-017 irq  out  1  level interrupt, equal to DONE AND IRQ_EN.

Function
REQ-018 Register map: 0x0 SRC, 0x4 DST, 0x8 LEN (LEN_WIDTH bits, zero-extended on read), 0xC CTRL/STATUS.
REQ-019 SRC/DST bits [1:0] read 0 and are ignored on write; SRC/DST/LEN writes honour byte lanes.
REQ-020 CTRL write, active only when wstrb[0]=1: bit0 START (self-clearing), bit1 IRQ_EN (stored), bit2 DONE_CLR (write-1-clear).
REQ-021 STATUS read: bit0 BUSY, bit1 IRQ_EN, bit2 DONE, [31:16] remaining word count; all other bits 0.
REQ-022 ready asserts exactly 1 cycle after select is sampled high, stays high 1 cycle, and deasserts before any next access; a write commits on the ready cycle.
REQ-023 ready=0 whenever select=0; data_o=0 when ready=0.
REQ-024 Writes to SRC/DST/LEN while BUSY=1 are ignored; reads remain live.
REQ-025 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
REQ-026 IDLE: on START with LEN≠0 -> RD_REQ, BUSY=1; on START with LEN=0 -> FINISH, with no bus traffic.
REQ-027 START while BUSY=1 is ignored; DONE_CLR in the same write still takes effect.
REQ-028 RD_REQ: when m_grant=1, assert m_valid, m_addr=SRC, m_wstrb=0000 -> RD_WAIT.
REQ-029 RD_WAIT: hold all master outputs stable until m_ready=1; capture m_rdata into the data buffer; drop m_valid next cycle -> WR_REQ.
REQ-030 WR_REQ: when m_grant=1, assert m_valid, m_addr=DST, m_wdata=buffer, m_wstrb=1111 -> WR_WAIT.
REQ-031 WR_WAIT: hold outputs until m_ready=1; then SRC+=4, DST+=4, LEN-=1; go to FINISH if the new LEN=0, else RD_REQ.
REQ-032 m_valid is low for at least 1 cycle between consecutive master requests.
REQ-033 Once m_valid is high, it is not withdrawn if m_grant falls; the request completes.
REQ-034 Address increment wraps modulo 2^32; no error is flagged.
REQ-035 FINISH: BUSY=0, DONE=1 -> IDLE, in one cycle.
REQ-036 If DONE_CLR is written on the same edge DONE is set, DONE is set (set wins).
REQ-037 Minimum per-word cost: 4 cycles plus responder wait states plus grant stalls.

Reset
REQ-038 On reset=1 sampled at an edge, these all take 0 on the next edge, including mid-transfer: SRC, DST, LEN, IRQ_EN, DONE, BUSY, buffer, ready, data_o, m_valid, m_addr, m_wstrb, m_wdata, irq. The FSM returns to IDLE.
REQ-039 A transfer aborted by reset is not resumed, and DONE is not set.

Verification
REQ-040 Program SRC=0x20000, DST=0x20100, LEN=3, write CTRL=0x3, responder 0-wait -> 3 reads then 3 writes interleaved at the correct addresses; then DONE=1, irq=1, STATUS=0x6.
REQ-041 LEN=0 with START -> no m_valid pulse; DONE=1 within 2 cycles of the ready cycle.
REQ-042 Responder inserts 5 wait states and m_grant toggles mid-request -> m_addr, m_wstrb and m_wdata stay stable and m_valid stays high until m_ready; data is copied intact.
REQ-043 Write SRC=0xFFFF_FFFC, LEN=2 -> second read at 0x0000_0000; write LEN=5 while busy -> LEN unaffected.
REQ-044 Assert reset during WR_WAIT of word 2 of 4 -> all outputs 0 next edge; DONE=0; a new START then runs cleanly.
REQ-045 Write CTRL=0x4 with DONE=1 -> DONE=0 and irq=0; write CTRL=0x4 on the FINISH edge -> DONE=1.

Source files
------------

// File: rtl/dma_copy_if.sv
// Bus interfaces for dma_copy: a config-register port and a single-master memory port.
interface dma_cfg_if;
    logic        select;
    logic [3:0]  wstrb;
    logic [3:0]  addr;
    logic [31:0] data_i;
    logic        ready;
    logic [31:0] data_o;

    modport master (output select, wstrb, addr, data_i, input ready, data_o);
    modport slave  (input select, wstrb, addr, data_i, output ready, data_o);
endinterface

interface dma_bus_if;
    logic        m_grant;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    modport master (input m_grant, m_ready, m_rdata, output m_valid, m_addr, m_wstrb, m_wdata);
    modport slave  (output m_grant, m_ready, m_rdata, input m_valid, m_addr, m_wstrb, m_wdata);
endinterface

// File: rtl/dma_copy.sv
// Word-by-word memory copy engine: programmed through a 4-register config port,
// moves LEN words from SRC to DST over a granted master bus, then raises DONE.
module dma_copy #(
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    dma_cfg_if.slave     cfg,
    dma_bus_if.master    bus,
    output logic         irq
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;
    localparam logic [2:0] FINISH  = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [31:0]          src_q, src_d, dst_q, dst_d, buf_q, buf_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 irq_en_q, irq_en_d, done_q, done_d, busy_q, busy_d;
    logic                 ready_q, ready_d, irq_q, irq_d;
    logic [31:0]          data_o_q, data_o_d;
    logic                 m_valid_q, m_valid_d;
    logic [31:0]          m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [3:0]           m_wstrb_q, m_wstrb_d;

    logic        acc_c, commit_c, ctrl_wr_c, start_c, clr_c;
    logic [31:0] rdata_c;
    logic        unused_c;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Access decode: first select cycle launches the read, the ready cycle commits writes
    assign acc_c     = cfg.select && !ready_q;
    assign commit_c  = cfg.select && ready_q && (cfg.wstrb != 4'b0000);
    assign ctrl_wr_c = commit_c && (cfg.addr[3:2] == 2'd3) && cfg.wstrb[0];
    assign start_c   = ctrl_wr_c && cfg.data_i[0];
    assign clr_c     = ctrl_wr_c && cfg.data_i[2];
    assign unused_c  = ^cfg.addr[1:0];

    always_comb begin
        rdata_c = 32'h0;
        case (cfg.addr[3:2])
            2'd0:    rdata_c = src_q;
            2'd1:    rdata_c = dst_q;
            2'd2:    rdata_c = 32'(len_q);
            default: rdata_c = {16'(len_q), 13'h0, done_q, irq_en_q, busy_q};
        endcase
    end

    // Register file updates and transfer sequencing
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        buf_d     = buf_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        busy_d    = busy_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_wstrb_d = m_wstrb_q;
        m_wdata_d = m_wdata_q;
        ready_d   = acc_c;
        data_o_d  = acc_c ? rdata_c : 32'h0;

        if (commit_c && !busy_q) begin
            case (cfg.addr[3:2])
                2'd0:    src_d = merge_be(src_q, cfg.data_i, cfg.wstrb) & ~32'h3;
                2'd1:    dst_d = merge_be(dst_q, cfg.data_i, cfg.wstrb) & ~32'h3;
                2'd2:    len_d = LEN_WIDTH'(merge_be(32'(len_q), cfg.data_i, cfg.wstrb));
                default: ;
            endcase
        end
        if (ctrl_wr_c) irq_en_d = cfg.data_i[1];

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    if (len_q != '0) begin
                        state_d = RD_REQ;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            RD_REQ: begin
                if (bus.m_grant) begin
                    m_valid_d = 1'b1;
                    m_addr_d  = src_q;
                    m_wstrb_d = 4'b0000;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.m_ready) begin
                    buf_d     = bus.m_rdata;
                    m_valid_d = 1'b0;
                    state_d   = WR_REQ;
                end
            end
            WR_REQ: begin
                if (bus.m_grant) begin
                    m_valid_d = 1'b1;
                    m_addr_d  = dst_q;
                    m_wdata_d = buf_q;
                    m_wstrb_d = 4'b1111;
                    state_d   = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    src_d     = src_q + 32'd4;
                    dst_d     = dst_q + 32'd4;
                    len_d     = len_q - LEN_WIDTH'(1);
                    if (len_q == LEN_WIDTH'(1)) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Completion wins over a simultaneous clear
        if (clr_c) done_d = 1'b0;
        if (state_q == FINISH) done_d = 1'b1;
        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            src_q     <= 32'h0;
            dst_q     <= 32'h0;
            len_q     <= '0;
            buf_q     <= 32'h0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            data_o_q  <= 32'h0;
            m_valid_q <= 1'b0;
            m_addr_q  <= 32'h0;
            m_wstrb_q <= 4'h0;
            m_wdata_q <= 32'h0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            buf_q     <= buf_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            data_o_q  <= data_o_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_wstrb_q <= m_wstrb_d;
            m_wdata_q <= m_wdata_d;
            irq_q     <= irq_d;
        end
    end

    assign cfg.ready   = ready_q;
    assign cfg.data_o  = data_o_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wstrb = m_wstrb_q;
    assign bus.m_wdata = m_wdata_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: scoreboard of expected bus requests checked by a responder model.
module tb_dma_copy;

    logic clk = 1'b0;
    logic reset;
    logic irq;

    dma_cfg_if cfg ();
    dma_bus_if bus ();

    dma_copy #(.LEN_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .cfg   (cfg),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t              exp_q[$];
    logic [31:0]       mem [logic [31:0]];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                wait_cfg = 0;
    logic              grant_toggle = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] seed(input logic [31:0] a);
        return 32'(a * 32'd2654435761) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_DEAD;
    endfunction

    // Responder: inserts wait_cfg wait states per request, checks every valid cycle against the queue head
    initial begin : responder
        int   wcnt;
        txn_t e;
        wcnt        = 0;
        bus.m_ready = 1'b0;
        bus.m_rdata = 32'h0;
        bus.m_grant = 1'b1;
        forever begin
            @(negedge clk);
            bus.m_grant = grant_toggle ? ~bus.m_grant : 1'b1;
            bus.m_ready = 1'b0;
            if (!reset && bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'(bus.m_valid), 32'h0);
                end else begin
                    e = exp_q[0];
                    check("m_addr", bus.m_addr, e.addr);
                    check("m_wstrb", 32'(bus.m_wstrb), e.wr ? 32'hF : 32'h0);
                    if (e.wr) check("m_wdata", bus.m_wdata, e.data);
                    if (wcnt < wait_cfg) begin
                        wcnt++;
                    end else begin
                        wcnt        = 0;
                        bus.m_ready = 1'b1;
                        if (e.wr) mem[bus.m_addr] = bus.m_wdata;
                        else      bus.m_rdata     = e.data;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic cfg_access(input logic [3:0] a, input logic [3:0] be,
                              input logic [31:0] wd, output logic [31:0] rd);
        int n;
        @(negedge clk);
        cfg.select = 1'b1;
        cfg.addr   = a;
        cfg.wstrb  = be;
        cfg.data_i = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg.ready && n < 8);
        check("ready_latency", 32'(n), 32'd1);
        rd = cfg.data_o;
        @(negedge clk);
        cfg.select = 1'b0;
        cfg.wstrb  = 4'h0;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be = 4'hF);
        logic [31:0] dummy;
        cfg_access(a, be, wd, dummy);
    endtask

    task automatic cfg_rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        cfg_access(a, 4'h0, 32'h0, rd);
        check(tag, rd, exp);
    endtask

    task automatic queue_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({1'b0, 32'(src + 32'(4 * i)), seed(32'(src + 32'(4 * i)))});
            exp_q.push_back({1'b1, 32'(dst + 32'(4 * i)), seed(32'(src + 32'(4 * i)))});
        end
    endtask

    task automatic check_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        for (int i = 0; i < len; i++)
            check("copy_data", mem_get(32'(dst + 32'(4 * i))), seed(32'(src + 32'(4 * i))));
    endtask

    task automatic wait_done();
        logic [31:0] st;
        int          n;
        n  = 0;
        st = 32'h0;
        while (n < 100) begin
            cfg_access(4'hC, 4'h0, 32'h0, st);
            if (!st[0] && st[2]) break;
            n++;
        end
        if (n >= 100) check("done_timeout", st, 32'h4);
    endtask

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                              input int len, input logic [31:0] ctrl);
        cfg_wr(4'h0, src);
        cfg_wr(4'h4, dst);
        cfg_wr(4'h8, 32'(len));
        queue_copy(src, dst, len);
        cfg_wr(4'hC, ctrl);
    endtask

    initial begin : stim
        int found;
        cfg.select = 1'b0;
        cfg.addr   = 4'h0;
        cfg.wstrb  = 4'h0;
        cfg.data_i = 32'h0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(cfg.ready), 32'h0);
        check("rst_data_o", cfg.data_o, 32'h0);
        check("rst_m_valid", 32'(bus.m_valid), 32'h0);
        check("rst_m_addr", bus.m_addr, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        cfg_rd_chk("rst_status", 4'hC, 32'h0);
        cfg_rd_chk("rst_src", 4'h0, 32'h0);

        // Basic 3-word copy with interrupt enabled
        wait_cfg = 0;
        start_copy(32'h0002_0000, 32'h0002_0100, 3, 32'h3);
        wait_done();
        check_copy(32'h0002_0000, 32'h0002_0100, 3);
        cfg_rd_chk("status_done", 4'hC, 32'h6);
        check("irq_set", 32'(irq), 32'h1);
        cfg_rd_chk("src_after", 4'h0, 32'h0002_000C);
        cfg_rd_chk("dst_after", 4'h4, 32'h0002_010C);
        check("sb_empty_1", 32'(exp_q.size()), 32'h0);
        check("idle_ready", 32'(cfg.ready), 32'h0);
        check("idle_data_o", cfg.data_o, 32'h0);

        // Byte-lane writes, low address bits forced to zero
        cfg_wr(4'h0, 32'hAABB_CCFF, 4'b0001);
        cfg_rd_chk("src_lane", 4'h0, 32'h0002_00FC);
        cfg_wr(4'h4, 32'h1234_5678, 4'b1100);
        cfg_rd_chk("dst_lane", 4'h4, 32'h1234_010C);
        cfg_wr(4'h8, 32'hFFFF_0102, 4'b0001);
        cfg_rd_chk("len_lane", 4'h8, 32'h0000_0002);

        // DONE clear drops irq
        cfg_wr(4'hC, 32'h4);
        cfg_rd_chk("status_clr", 4'hC, 32'h0000_0002 << 16);
        check("irq_clr", 32'(irq), 32'h0);

        // Zero-length start: no bus traffic, DONE quickly
        cfg_wr(4'h8, 32'h0);
        cfg_wr(4'hC, 32'h3);
        @(negedge clk);
        check("len0_irq", 32'(irq), 32'h1);
        cfg_rd_chk("len0_status", 4'hC, 32'h6);
        cfg_wr(4'hC, 32'h4);

        // Wait states with a toggling grant
        wait_cfg     = 5;
        grant_toggle = 1'b1;
        start_copy(32'h0000_0100, 32'h0000_0300, 2, 32'h1);
        wait_done();
        check_copy(32'h0000_0100, 32'h0000_0300, 2);
        check("sb_empty_2", 32'(exp_q.size()), 32'h0);
        grant_toggle = 1'b0;
        cfg_wr(4'hC, 32'h4);

        // Source address wrap, LEN write ignored while busy
        wait_cfg = 3;
        start_copy(32'hFFFF_FFFC, 32'h0000_0400, 2, 32'h1);
        cfg_wr(4'h8, 32'h5);
        wait_done();
        check_copy(32'hFFFF_FFFC, 32'h0000_0400, 2);
        cfg_rd_chk("wrap_len", 4'h8, 32'h0);
        cfg_rd_chk("wrap_src", 4'h0, 32'h0000_0004);
        check("sb_empty_3", 32'(exp_q.size()), 32'h0);
        cfg_wr(4'hC, 32'h6);

        // Reset during the second write of a 4-word copy
        wait_cfg = 4;
        start_copy(32'h0000_0500, 32'h0000_0600, 4, 32'h3);
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (bus.m_valid && bus.m_wstrb == 4'hF && bus.m_addr == 32'h0000_0604) found = 1;
        end
        check("wr2_seen", 32'(found), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_m_valid", 32'(bus.m_valid), 32'h0);
        check("abort_m_addr", bus.m_addr, 32'h0);
        check("abort_m_wstrb", 32'(bus.m_wstrb), 32'h0);
        check("abort_m_wdata", bus.m_wdata, 32'h0);
        check("abort_irq", 32'(irq), 32'h0);
        check("abort_ready", 32'(cfg.ready), 32'h0);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_req", 32'(bus.m_valid), 32'h0);
        cfg_rd_chk("abort_status", 4'hC, 32'h0);
        cfg_rd_chk("abort_src", 4'h0, 32'h0);
        wait_cfg = 0;
        start_copy(32'h0000_0700, 32'h0000_0800, 2, 32'h1);
        wait_done();
        check_copy(32'h0000_0700, 32'h0000_0800, 2);
        check("sb_empty_4", 32'(exp_q.size()), 32'h0);
        cfg_wr(4'hC, 32'h4);
        cfg_rd_chk("clr_status", 4'hC, 32'h0);

        // DONE_CLR committed on the same edge DONE is set
        start_copy(32'h0000_0900, 32'h0000_0A00, 1, 32'h1);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (bus.m_valid && bus.m_wstrb == 4'hF && bus.m_addr == 32'h0000_0A00) found = 1;
        end
        check("last_wr_seen", 32'(found), 32'h1);
        cfg.select = 1'b1;
        cfg.addr   = 4'hC;
        cfg.wstrb  = 4'h1;
        cfg.data_i = 32'h4;
        @(negedge clk);
        check("race_ready", 32'(cfg.ready), 32'h1);
        @(negedge clk);
        cfg.select = 1'b0;
        cfg.wstrb  = 4'h0;
        cfg_rd_chk("race_done_wins", 4'hC, 32'h4);
        check_copy(32'h0000_0900, 32'h0000_0A00, 1);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
